// File: rtl/nr_div_pkg.sv
// Shared fixed-point constants, controller state encoding and seed-table helper
// for the Q9.55 Newton-Raphson divider controller.
package nr_div_pkg;

    localparam int Q_FRAC  = 55;
    localparam int Q_INT   = 9;
    localparam int Q_WIDTH = Q_INT + Q_FRAC;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_NORM = 3'd1,
        S_SEED = 3'd2,
        S_WAIT = 3'd3,
        S_MUL  = 3'd4,
        S_OUT  = 3'd5
    } state_e;

    // round(2^55 / (1 + (idx + 0.5) / 2^bits)), rewritten over integers;
    // the denominator is odd, so no exact .5 tie can occur.
    function automatic logic [Q_WIDTH-1:0] seed_entry(input int unsigned idx,
                                                      input int unsigned bits);
        logic [127:0] num;
        logic [127:0] den;
        logic [127:0] quo;
        num = 128'd1 << (Q_FRAC + 1 + bits);
        den = (128'd1 << (bits + 1)) + 128'(2 * idx + 1);
        quo = (num + (den >> 1)) / den;
        return quo[Q_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/nr_seed_lut.sv
// Combinational reciprocal seed table, indexed by the top fraction bits of the
// normalized divisor; entries are elaboration-time constants.
module nr_seed_lut
    import nr_div_pkg::*;
#(
    parameter int SEED_BITS = 4
) (
    input  logic [SEED_BITS-1:0] idx_i,
    output logic [Q_WIDTH-1:0]   seed_o
);

    logic [Q_WIDTH-1:0] table_w [2**SEED_BITS];

    for (genvar i = 0; i < 2**SEED_BITS; i++) begin : g_tab
        assign table_w[i] = seed_entry(i, SEED_BITS);
    end

    assign seed_o = table_w[idx_i];

endmodule

// File: rtl/nr_div_ctrl.sv
// Q9.55 divider sequencer: normalizes D, seeds and waits on an external reciprocal unit, scales A*R.
// `define NR_DIV_TIMEOUT_EN adds a WAIT watchdog and the out_tmo result flag.
//
//  state | meaning
//  IDLE  | ready for operands
//  NORM  | find leading one of D, normalize to [1,2), trap D==0
//  SEED  | pulse rcp_start with seed guess and normalized divisor
//  WAIT  | hold reciprocal request until rcp_done (or watchdog)
//  MUL   | Q = ((A*R)>>55) shifted back by the normalization amount
//  OUT   | present result until out_ready
module nr_div_ctrl
    import nr_div_pkg::*;
#(
    parameter int SEED_BITS  = 4,
    parameter int TMO_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [Q_WIDTH-1:0] in_a,
    input  logic [Q_WIDTH-1:0] in_d,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [Q_WIDTH-1:0] out_q,
    output logic               out_dz,
    output logic               out_ovf,
    output logic               rcp_start,
    output logic [Q_WIDTH-1:0] rcp_x,
    output logic [Q_WIDTH-1:0] rcp_d,
    input  logic [Q_WIDTH-1:0] rcp_result,
    input  logic               rcp_done
`ifdef NR_DIV_TIMEOUT_EN
    ,
    output logic               out_tmo
`endif
);

    state_e state_q, state_d;

    logic [Q_WIDTH-1:0]   a_q, d_q, r_q, q_q, rcp_x_q, rcp_d_q;
    logic signed [6:0]    sh_q, sh_d;
    logic                 dz_q, ovf_q;
    logic [5:0]           lead;
    logic [Q_WIDTH-1:0]   dn;
    logic [SEED_BITS-1:0] seed_idx;
    logic [Q_WIDTH-1:0]   seed;
    logic [127:0]         prod, p_scaled, shifted;
    logic                 ovf;
    logic                 wd_expired;

    always_comb begin
        lead = '0;
        for (int i = 0; i < Q_WIDTH; i++) begin
            if (d_q[i]) lead = 6'(i);
        end
        sh_d = $signed(7'(Q_FRAC)) - $signed({1'b0, lead});
        if (lead >= 6'(Q_FRAC)) dn = d_q >> (lead - 6'(Q_FRAC));
        else                    dn = d_q << (6'(Q_FRAC) - lead);
    end

    assign seed_idx = dn[Q_FRAC-1 -: SEED_BITS];

    nr_seed_lut #(.SEED_BITS(SEED_BITS)) u_seed_lut (
        .idx_i  (seed_idx),
        .seed_o (seed)
    );

    // P carries at most 73 significant bits, so a left shift of up to 55 still fits in 128.
    always_comb begin
        prod     = {64'd0, a_q} * {64'd0, r_q};
        p_scaled = prod >> Q_FRAC;
        if (!sh_q[6]) shifted = p_scaled << sh_q[5:0];
        else          shifted = p_scaled >> 6'(-sh_q);
        ovf = |shifted[127:64];
    end

`ifdef NR_DIV_TIMEOUT_EN
    localparam int WD_W = $clog2(TMO_CYCLES + 1);

    logic [WD_W-1:0] wd_q;
    logic            tmo_q;

    assign wd_expired = (wd_q == '0);
    assign out_tmo    = tmo_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_q  <= '0;
            tmo_q <= 1'b0;
        end else begin
            if (state_q == S_SEED)
                wd_q <= WD_W'(TMO_CYCLES - 1);
            else if (state_q == S_WAIT && !wd_expired)
                wd_q <= wd_q - 1'b1;
            if (state_d == S_OUT && state_q != S_OUT)
                tmo_q <= (state_q == S_WAIT);
        end
    end
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = S_NORM;
            S_NORM: state_d = (d_q == '0) ? S_OUT : S_SEED;
            S_SEED: state_d = S_WAIT;
            S_WAIT: begin
                if (rcp_done)        state_d = S_MUL;
                else if (wd_expired) state_d = S_OUT;
            end
            S_MUL:  state_d = S_OUT;
            S_OUT:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            rcp_x_q <= '0;
            rcp_d_q <= '0;
            sh_q    <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (in_valid) begin
                    a_q <= in_a;
                    d_q <= in_d;
                end
                S_NORM: if (d_q == '0) begin
                    q_q   <= '1;
                    dz_q  <= 1'b1;
                    ovf_q <= 1'b0;
                end else begin
                    rcp_d_q <= dn;
                    rcp_x_q <= seed;
                    sh_q    <= sh_d;
                end
                S_WAIT: if (rcp_done) begin
                    r_q <= rcp_result;
                end else if (wd_expired) begin
                    q_q   <= '0;
                    dz_q  <= 1'b0;
                    ovf_q <= 1'b0;
                end
                S_MUL: begin
                    q_q   <= ovf ? '1 : shifted[Q_WIDTH-1:0];
                    ovf_q <= ovf;
                    dz_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign rcp_start = (state_q == S_SEED);
    assign rcp_x     = rcp_x_q;
    assign rcp_d     = rcp_d_q;
    assign out_q     = q_q;
    assign out_dz    = dz_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_nr_div_ctrl.sv
// Bench for nr_div_ctrl: directed and random divisions, with the bench acting as the
// reciprocal unit and an arithmetic reference model for seed, normalization and quotient.
module tb_nr_div_ctrl;

    localparam int SB = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_a = '0;
    logic [63:0] in_d = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_q;
    logic        out_dz;
    logic        out_ovf;
    logic        rcp_start;
    logic [63:0] rcp_x;
    logic [63:0] rcp_d;
    logic [63:0] rcp_result = '0;
    logic        rcp_done = 1'b0;
`ifdef NR_DIV_TIMEOUT_EN
    logic        out_tmo;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nr_div_ctrl #(.SEED_BITS(SB), .TMO_CYCLES(64)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_d       (in_d),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_q      (out_q),
        .out_dz     (out_dz),
        .out_ovf    (out_ovf),
        .rcp_start  (rcp_start),
        .rcp_x      (rcp_x),
        .rcp_d      (rcp_d),
        .rcp_result (rcp_result),
        .rcp_done   (rcp_done)
`ifdef NR_DIV_TIMEOUT_EN
        ,
        .out_tmo    (out_tmo)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: value-level arithmetic on A, D and the true reciprocal of the normalized divisor.
    function automatic void model(input logic [63:0] a, input logic [63:0] d,
                                  output logic [63:0] dn, output logic [63:0] r,
                                  output logic [63:0] seed, output logic [63:0] q,
                                  output logic ovf);
        int           p;
        int           sh;
        int           sidx;
        logic [127:0] num, den, r_full;
        logic [255:0] val;
        p = 0;
        while (p < 63 && (d >> (p + 1)) != 64'd0) p++;
        sh = 55 - p;
        dn = (sh >= 0) ? (d << sh) : (d >> (-sh));
        r_full = (128'd1 << 110) / {64'd0, dn};
        r = r_full[63:0];
        sidx = int'((dn >> (55 - SB)) & ((64'd1 << SB) - 64'd1));
        num = 128'd1 << (56 + SB);
        den = 128'd32 + 128'(2 * sidx + 1);
        r_full = (2 * num + den) / (2 * den);
        seed = r_full[63:0];
        val = ({192'd0, a} * {192'd0, r}) >> 55;
        val = (sh >= 0) ? (val << sh) : (val >> (-sh));
        ovf = (val >= (256'd1 << 64));
        q = ovf ? 64'hFFFF_FFFF_FFFF_FFFF : val[63:0];
    endfunction

    // w = cycles from rcp_start to rcp_done; w <= 0 withholds rcp_done entirely.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] d,
                          input int w, input int hold);
        logic [63:0] dn, r, seed, q_exp, q_seen;
        logic        ovf;
        bit          zero, tmo;
        int          s, o, c, lat_exp;
        zero = (d == 64'd0);
        tmo  = !zero && (w <= 0);
        dn = '0; r = '0; seed = '0; ovf = 1'b0; q_exp = 64'hFFFF_FFFF_FFFF_FFFF;
        if (!zero) model(a, d, dn, r, seed, q_exp, ovf);
        if (tmo) q_exp = 64'd0;

        @(negedge clk);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; in_a = a; in_d = d;
        @(negedge clk);
        in_valid = 1'b0; in_a = {$urandom(), $urandom()}; in_d = {$urandom(), $urandom()};

        s = -1; o = -1; c = 1;
        while (o < 0 && c <= 200) begin
            rcp_done = 1'b0;
            if (rcp_start) begin
                s = c;
                chk({tag, "_rcp_d"}, rcp_d, dn);
                chk({tag, "_rcp_x"}, rcp_x, seed);
            end
            if (out_valid) begin
                o = c;
            end else begin
                chk({tag, "_busy"}, {63'd0, in_ready}, 64'd0);
                if (s >= 0 && w > 0 && c == s + w) begin
                    chk({tag, "_rcp_d_hold"}, rcp_d, dn);
                    rcp_done = 1'b1; rcp_result = r;
                end
                @(negedge clk);
                c++;
            end
        end

        if (zero) begin
            chk({tag, "_no_start"}, 64'(s), 64'hFFFF_FFFF_FFFF_FFFF);
            lat_exp = 2;
        end else begin
            chk({tag, "_start_cyc"}, 64'(s), 64'd2);
            lat_exp = tmo ? 2 + 65 : 2 + w + 2;
        end
        chk({tag, "_latency"}, 64'(o), 64'(lat_exp));
        chk({tag, "_q"}, out_q, q_exp);
        chk({tag, "_dz"}, {63'd0, out_dz}, {63'd0, zero});
        chk({tag, "_ovf"}, {63'd0, out_ovf}, {63'd0, ovf});
`ifdef NR_DIV_TIMEOUT_EN
        chk({tag, "_tmo"}, {63'd0, out_tmo}, {63'd0, tmo});
`endif
        q_seen = out_q;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
            chk({tag, "_hold_q"}, out_q, q_seen);
            chk({tag, "_hold_ready"}, {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_done_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_done_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        logic [63:0] ra, rd;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_rcp_start", {63'd0, rcp_start}, 64'd0);
        chk("rst_out_q", out_q, 64'd0);
        chk("rst_rcp_x", rcp_x, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Stray rcp_done while idle must not start or complete anything.
        rcp_done = 1'b1; rcp_result = 64'h1234;
        @(negedge clk);
        rcp_done = 1'b0;
        chk("idle_done_valid", {63'd0, out_valid}, 64'd0);
        chk("idle_done_ready", {63'd0, in_ready}, 64'd1);

        run_op("one_by_two", 64'h0080_0000_0000_0000, 64'h0100_0000_0000_0000, 1, 0);
        run_op("div_zero",   64'h0123_4567_89AB_CDEF, 64'd0, 1, 2);
        run_op("sat_ovf",    64'h8000_0000_0000_0000, 64'd1, 2, 0);
        run_op("top_bit_d",  64'h0400_0000_0000_0000, 64'h8000_0000_0000_0000, 3, 0);
        run_op("hold5",      64'h0300_0000_0000_0000, 64'h0180_0000_0000_0000, 4, 5);

        for (int k = 0; k < 24; k++) begin
            ra = {$urandom(), $urandom()} >> $urandom_range(0, 63);
            rd = {$urandom(), $urandom()} >> $urandom_range(0, 63);
            if (rd == 64'd0) rd = 64'd3;
            run_op("rand", ra, rd, int'($urandom_range(1, 6)), int'($urandom_range(0, 3)));
        end

        // Reset while waiting on the reciprocal; the late rcp_done must be ignored.
        @(negedge clk);
        in_valid = 1'b1; in_a = 64'h0080_0000_0000_0000; in_d = 64'h00C0_0000_0000_0000;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 10 && !rcp_start; i++) @(negedge clk);
        chk("rst_wait_start", {63'd0, rcp_start}, 64'd1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_wait_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_wait_rcp_d", rcp_d, 64'd0);
        chk("rst_wait_out_q", out_q, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rcp_done = 1'b1; rcp_result = 64'h00AA_AAAA_AAAA_AAAB;
        @(negedge clk);
        rcp_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("rst_late_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_late_ready", {63'd0, in_ready}, 64'd1);
            @(negedge clk);
        end

`ifdef NR_DIV_TIMEOUT_EN
        run_op("timeout", 64'h0080_0000_0000_0000, 64'h0100_0000_0000_0000, 0, 1);
        run_op("after_tmo", 64'h0200_0000_0000_0000, 64'h0040_0000_0000_0000, 2, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
